// File: rtl/scrambler_gen.sv
// scrambler_gen: self-synchronous multiplicative scrambler/descrambler,
// polynomial 1 + x^TAP_A + x^TAP_B, with one registered valid/ready stage
// and a lock indicator that tracks how much history came from line data.
// Optional feature macro: SCRAMBLER_BYPASS_EN adds a quasi-static bypass port.
module scrambler_gen #(
    parameter int               DATA_WIDTH = 116,
    parameter int               TAP_A      = 39,
    parameter int               TAP_B      = 58,
    parameter int               DESCRAMBLE = 0,
    parameter logic [TAP_B-1:0] SEED       = TAP_B'(58'h155555555555555)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  seed_load,
`ifdef SCRAMBLER_BYPASS_EN
    input  logic                  bypass,
`endif
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  locked
);

    localparam int CW = $clog2(TAP_B + 1);

    logic [TAP_B-1:0]            hist;
    logic [TAP_B-1:0]            hist_nxt;
    logic [CW-1:0]               cnt;
    logic [CW-1:0]               cnt_nxt;
    logic [DATA_WIDTH-1:0]       beat_out;
    logic [DATA_WIDTH-1:0]       line;
    logic [TAP_B+DATA_WIDTH-1:0] line_cat;
    logic                        accept;
    logic                        byp;

`ifdef SCRAMBLER_BYPASS_EN
    assign byp = bypass;
`else
    assign byp = 1'b0;
`endif

    // Bit-serial evaluation unrolled over the beat. ext holds the line
    // stream: ext[TAP_B+k] is line bit k of this beat, ext[TAP_B+k] for k<0
    // falls into the history. For scrambling the line bit is the output bit,
    // so later bits of the beat see earlier outputs of the same beat.
    function automatic logic [DATA_WIDTH-1:0] scr_beat(
        input logic [TAP_B-1:0]      h,
        input logic [DATA_WIDTH-1:0] din,
        input logic                  bp
    );
        logic [TAP_B+DATA_WIDTH-1:0] ext;
        logic [DATA_WIDTH-1:0]       res;
        ext            = '0;
        ext[TAP_B-1:0] = h;
        res            = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            res[i]         = bp ? din[i] : (din[i] ^ ext[TAP_B+i-TAP_A] ^ ext[i]);
            ext[TAP_B+i]   = (DESCRAMBLE != 0 || bp) ? din[i] : res[i];
        end
        return res;
    endfunction

    assign accept   = s_valid && s_ready;
    assign s_ready  = !m_valid || m_ready;
    assign beat_out = scr_beat(hist, s_data, byp);
    // In bypass beat_out equals s_data, so the line selection stays correct.
    assign line     = (DESCRAMBLE != 0) ? s_data : beat_out;
    assign line_cat = {line, hist};
    assign hist_nxt = line_cat[TAP_B+DATA_WIDTH-1 -: TAP_B];
    assign locked   = (cnt == CW'(TAP_B));

    // Lock counter advance: add the beat width, saturating at TAP_B.
    always_comb begin
        cnt_nxt = cnt;
        if (int'(cnt) + DATA_WIDTH >= TAP_B)
            cnt_nxt = CW'(TAP_B);
        else
            cnt_nxt = cnt + CW'(DATA_WIDTH);
    end

    // History and lock counter; a reload wins over a same-edge accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= SEED;
            cnt  <= '0;
        end else if (seed_load) begin
            hist <= SEED;
            cnt  <= '0;
        end else if (accept) begin
            hist <= hist_nxt;
            cnt  <= cnt_nxt;
        end
    end

    // Output register stage: load on accept, drop valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= beat_out;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
